fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of the dual-clock FIFO, running entirely in the read clock domain.
- Pops DSIZE-bit words through the FIFO's rinc/rempty/rdata interface.
- Packs PACK consecutive words, little-endian, into one DSIZE*PACK-bit beat.
- Presents beats on a registered valid/ready stream, with a flush request that emits a partial beat carrying a byte-lane keep mask.

Parameters:
DSIZE, 8, width of one FIFO word (must match the FIFO's DSIZE)
PACK, 4, FIFO words per output beat; legal range 2..16
ODW, DSIZE*PACK, derived output data width; not overridden

Ports:
rclk  input  1  read-domain clock, shared with the FIFO read side
rrst_n  input  1  synchronous, active-low reset
rdata  input  DSIZE  FIFO read data; valid whenever rempty=0 (combinational memory read)
rempty  input  1  FIFO empty flag, registered in rclk domain
rinc  output  1  FIFO pop strobe; word is consumed at the rclk edge where rinc=1
flush  input  1  single-cycle request to close the current partial beat
flush_busy  output  1  high from the cycle after flush is sampled until it is serviced
out_valid  output  1  output beat valid
out_ready  input  1  downstream accept
out_data  output  ODW  packed beat; first-popped word in bits [DSIZE-1:0]
out_keep  output  PACK  per-word valid mask for out_data
out_last  output  1  beat was closed by a flush

Behaviour:
Clock, reset and reset values:
- Single clock rclk. Reset is synchronous, active-low on rrst_n.
- Reset values: out_valid=0, out_data=0, out_keep=0, out_last=0, flush_busy=0.
- Reset values of internal state: lane counter cnt=0, accumulator=0, keep accumulator=0.
- rinc is forced to 0 combinationally while rrst_n=0.
- Reset mid-operation discards the partial accumulator and any held beat; no beat is emitted.

Internal state:
- Accumulator of PACK-1 words, cnt in 0..PACK-1, acc_keep.
- One output register: out_data, out_keep, out_last, out_valid.
- slot_free = !out_valid | out_ready.

Pop rule (combinational):
- rinc = rrst_n & !rempty & !flush_busy & !(cnt==PACK-1 & !slot_free).
- The word is captured into lane cnt at the same edge the pop takes effect.

Beat completion:
- On a pop with cnt==PACK-1, load the output register with {rdata, acc}, keep all ones, last=0.
- Then set cnt=0 and clear the accumulator.
- Otherwise a pop stores the word into lane cnt, sets acc_keep[cnt], and increments cnt.

Output handshake:
- A beat transfers on out_valid & out_ready.
- out_valid drops the next cycle unless a new beat loads in the same cycle; back-to-back beats are allowed.
- While out_valid=1 & out_ready=0: out_data, out_keep and out_last are held stable.

Flush:
- flush sampled high sets flush_busy. A pop in that same cycle still happens and is included in the flushed beat.
- If that pop completes the word, the full beat loads with out_last=1 and flush_busy is not set.
- While flush_busy: no pops. On the first cycle with slot_free:
  - if cnt>0, load {zero-padded acc, acc_keep} with out_last=1;
  - if cnt==0, emit nothing.
  - In both cases clear flush_busy, cnt, acc and acc_keep.
- flush asserted while flush_busy is already high is ignored.
- Unused lanes of a partial beat are 0.

Latency:
- Pop of the final word of a beat to out_valid is 1 cycle.
- flush sampled to out_valid is 2 cycles minimum (flush_busy stage, then load).

Throughput:
- One FIFO word per cycle sustained when out_ready=1.
- No bubble at beat boundaries.

Decomposition:
- Shared package fifo_pkg holds: the default DSIZE and PACK constants, and a function computing ODW and the cnt width as $clog2(PACK).
- The output register with its hold/load logic is one natural sub-module: out_beat_reg (parameter ODW, PACK).
- Packing and flush control stay in fifo_rd_packer.

Test Plan:
- Steady streaming:
  - Stimulus: FIFO holds 01..08, out_ready=1.
  - Response: rinc high 8 consecutive cycles; beats 0x04030201 then 0x08070605, both keep=0xF, last=0, second beat 4 cycles after the first.
- Backpressure:
  - Stimulus: out_ready=0, 8 words queued.
  - Response: beat 0x04030201 held stable; words 05,06,07 accumulate, then rinc=0 with rempty=0.
  - Stimulus: raise out_ready.
  - Response: 0x04030201 accepted, then 0x08070605.
- Partial flush:
  - Stimulus: words AA,BB,CC, then flush.
  - Response: flush_busy=1 one cycle; beat 0x00CCBBAA, keep=0x7, last=1; cnt returns to 0.
- Flush on a word boundary:
  - Stimulus: flush in the same cycle as the pop of word 4 (11,22,33,44).
  - Response: beat 0x44332211, keep=0xF, last=1; flush_busy stays 0.
  - Stimulus: flush with cnt=0.
  - Response: flush_busy 1 cycle, no beat.
- Flush blocked by backpressure:
  - Stimulus: out_valid held with out_ready=0, 2 words accumulated, flush.
  - Response: flush_busy stays high and rinc=0 until out_ready=1; next beat keep=0x3, last=1.
- Reset mid-beat:
  - Stimulus: drop rrst_n with cnt=2 and out_valid=1.
  - Response: at the next edge out_valid=0, out_keep=0, flush_busy=0; rinc=0 throughout reset.
  - After release: the next full beat starts at lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the FIFO read-side packer.
package fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_PACK  = 4;

    function automatic int calc_odw(input int dsize, input int pack);
        return dsize * pack;
    endfunction

    function automatic int calc_cnt_w(input int pack);
        return $clog2(pack);
    endfunction

endpackage

// File: rtl/out_beat_reg.sv
// Single-entry output register for packed beats: loads a new beat when told,
// holds it stable until accepted, and drops valid after acceptance.
module out_beat_reg #(
    parameter int ODW  = 32,
    parameter int PACK = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [ODW-1:0]  load_data,
    input  logic [PACK-1:0] load_keep,
    input  logic            load_last,
    input  logic            ready,
    output logic            valid,
    output logic [ODW-1:0]  data,
    output logic [PACK-1:0] keep,
    output logic            last
);

    // The parent only loads when the slot is free, so a load never overwrites
    // a beat that is still waiting for acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops DSIZE-bit words from the FIFO read port and packs PACK of them,
// little-endian, into one output beat; flush closes a partial beat.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int PACK  = DEF_PACK
) (
    input  logic                               rclk,
    input  logic                               rrst_n,
    input  logic [DSIZE-1:0]                   rdata,
    input  logic                               rempty,
    output logic                               rinc,
    input  logic                               flush,
    output logic                               flush_busy,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [calc_odw(DSIZE, PACK)-1:0]   out_data,
    output logic [PACK-1:0]                    out_keep,
    output logic                               out_last
);

    localparam int ODW = calc_odw(DSIZE, PACK);
    localparam int CW  = calc_cnt_w(PACK);
    localparam logic [CW-1:0] LAST_LANE = CW'(PACK - 1);

    logic [CW-1:0]              cnt;
    logic [(PACK-1)*DSIZE-1:0]  acc;
    logic [PACK-2:0]            acc_keep;

    logic            slot_free;
    logic            at_last;
    logic            load_full;
    logic            drain;
    logic            load;
    logic [ODW-1:0]  load_data;
    logic [PACK-1:0] load_keep;
    logic            load_last;

    always_comb begin
        slot_free = !out_valid || out_ready;
        at_last   = (cnt == LAST_LANE);
        rinc      = rrst_n && !rempty && !flush_busy && !(at_last && !slot_free);
        load_full = rinc && at_last;
        drain     = flush_busy && slot_free;
        load      = load_full || (drain && (cnt != '0));
        // A flush that coincides with the completing pop marks that full beat as last.
        if (load_full) begin
            load_data = {rdata, acc};
            load_keep = '1;
            load_last = flush;
        end else begin
            load_data = {{DSIZE{1'b0}}, acc};
            load_keep = {1'b0, acc_keep};
            load_last = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            cnt        <= '0;
            acc        <= '0;
            acc_keep   <= '0;
            flush_busy <= 1'b0;
        end else begin
            if (drain) begin
                cnt        <= '0;
                acc        <= '0;
                acc_keep   <= '0;
                flush_busy <= 1'b0;
            end else if (flush && !flush_busy && !load_full) begin
                flush_busy <= 1'b1;
            end
            // Pops never coincide with a drain: flush_busy blocks rinc.
            if (rinc) begin
                if (at_last) begin
                    cnt      <= '0;
                    acc      <= '0;
                    acc_keep <= '0;
                end else begin
                    for (int i = 0; i < PACK - 1; i++) begin
                        if (cnt == CW'(i)) begin
                            acc[i*DSIZE +: DSIZE] <= rdata;
                            acc_keep[i]           <= 1'b1;
                        end
                    end
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    out_beat_reg #(
        .ODW  (ODW),
        .PACK (PACK)
    ) u_out_beat_reg (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .keep      (out_keep),
        .last      (out_last)
    );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios plus randomized traffic
// scored against a word-list reference model.
module tb_fifo_rd_packer;

    localparam int DSIZE = 8;
    localparam int PACK  = 4;
    localparam int ODW   = DSIZE * PACK;

    logic             rclk = 1'b0;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             flush;
    logic             flush_busy;
    logic             out_valid;
    logic             out_ready;
    logic [ODW-1:0]   out_data;
    logic [PACK-1:0]  out_keep;
    logic             out_last;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(
        .DSIZE (DSIZE),
        .PACK  (PACK)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rdata      (rdata),
        .rempty     (rempty),
        .rinc       (rinc),
        .flush      (flush),
        .flush_busy (flush_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last)
    );

    typedef struct packed {
        logic [ODW-1:0]  data;
        logic [PACK-1:0] keep;
        logic            last;
    } beat_t;

    beat_t            exp_q[$];
    beat_t            got_log[$];
    int               got_cyc[$];
    logic [DSIZE-1:0] fifo_q[$];
    logic [DSIZE-1:0] cur[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rinc_cnt, rinc_run, rinc_max, fb_cnt, n0;

    logic             drv_ready, drv_flush;
    logic             prev_hold;
    logic [ODW-1:0]   prev_data;
    logic [PACK-1:0]  prev_keep;
    logic             prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference beat built from the words popped since the last beat boundary.
    function automatic beat_t make_beat(input logic last_f);
        beat_t b;
        b.data = '0;
        b.keep = '0;
        b.last = last_f;
        for (int i = 0; i < cur.size(); i++) begin
            b.data[i*DSIZE +: DSIZE] = cur[i];
            b.keep[i] = 1'b1;
        end
        return b;
    endfunction

    task automatic push_words(input logic [DSIZE-1:0] first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(first + DSIZE'(i));
    endtask

    // One clock cycle: drive, observe away from the edge, update the model, advance.
    task automatic tick();
        beat_t b;
        logic  completed;
        completed = 1'b0;
        rempty    = (fifo_q.size() == 0);
        rdata     = rempty ? '0 : fifo_q[0];
        out_ready = drv_ready;
        flush     = drv_flush;
        #1;
        if (!rrst_n) begin
            check("rinc_in_reset", rinc, 0);
            cur.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("rinc_when_empty", rinc & rempty, 0);
            if (prev_hold)
                check("hold_stable", {out_data, out_keep, out_last}, {prev_data, prev_keep, prev_last});
            if (out_valid && out_ready) begin
                b.data = out_data;
                b.keep = out_keep;
                b.last = out_last;
                got_log.push_back(b);
                got_cyc.push_back(cyc);
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    check("beat_content", b, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (rinc) begin
                cur.push_back(fifo_q.pop_front());
                if (cur.size() == PACK) begin
                    exp_q.push_back(make_beat(flush));
                    cur.delete();
                    completed = 1'b1;
                end
            end
            if (flush && !flush_busy && !completed && cur.size() > 0) begin
                exp_q.push_back(make_beat(1'b1));
                cur.delete();
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
            prev_last = out_last;
            if (rinc) begin
                rinc_cnt++;
                rinc_run++;
                if (rinc_run > rinc_max) rinc_max = rinc_run;
            end else begin
                rinc_run = 0;
            end
            if (flush_busy) fb_cnt++;
        end
        @(posedge rclk);
        cyc++;
        @(negedge rclk);
    endtask

    task automatic clear_counts();
        rinc_cnt = 0;
        rinc_run = 0;
        rinc_max = 0;
        fb_cnt   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rrst_n    = 1'b0;
        drv_ready = 1'b0;
        drv_flush = 1'b0;
        prev_hold = 1'b0;
        rempty    = 1'b1;
        rdata     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clear_counts();
        @(negedge rclk);
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_keep", out_keep, 0);
        check("rst_out_last", out_last, 0);
        check("rst_flush_busy", flush_busy, 0);
        rrst_n = 1'b1;

        // Steady streaming
        clear_counts();
        n0 = got_log.size();
        push_words(8'h01, 8);
        drv_ready = 1'b1;
        repeat (12) tick();
        check("stream_rinc_count", rinc_cnt, 8);
        check("stream_rinc_run", rinc_max, 8);
        check("stream_beats", got_log.size() - n0, 2);
        if (got_log.size() >= n0 + 2) begin
            check("stream_beat0", got_log[n0], {32'h04030201, 4'hF, 1'b0});
            check("stream_beat1", got_log[n0+1], {32'h08070605, 4'hF, 1'b0});
            check("stream_gap", got_cyc[n0+1] - got_cyc[n0], 4);
        end

        // Backpressure
        clear_counts();
        n0 = got_log.size();
        drv_ready = 1'b0;
        push_words(8'h01, 8);
        repeat (8) tick();
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 32'h04030201);
        check("bp_pops", rinc_cnt, 7);
        check("bp_fifo_left", fifo_q.size(), 1);
        drv_ready = 1'b1;
        repeat (6) tick();
        check("bp_beats", got_log.size() - n0, 2);
        if (got_log.size() >= n0 + 2) begin
            check("bp_beat0", got_log[n0].data, 32'h04030201);
            check("bp_beat1", got_log[n0+1].data, 32'h08070605);
        end

        // Partial flush
        clear_counts();
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        fifo_q.push_back(8'hCC);
        repeat (4) tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        repeat (4) tick();
        check("pflush_busy_cycles", fb_cnt, 1);
        check("pflush_beat", got_log[$], {32'h00CCBBAA, 4'h7, 1'b1});

        // Flush on the completing pop, then flush with nothing accumulated
        clear_counts();
        push_words(8'h11, 1);
        push_words(8'h22, 1);
        push_words(8'h33, 1);
        push_words(8'h44, 1);
        repeat (3) tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        repeat (3) tick();
        check("bflush_beat", got_log[$], {32'h44332211, 4'hF, 1'b1});
        check("bflush_no_busy", fb_cnt, 0);
        clear_counts();
        n0 = got_log.size();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        repeat (4) tick();
        check("eflush_busy_cycles", fb_cnt, 1);
        check("eflush_no_beat", got_log.size() - n0, 0);

        // Flush blocked by backpressure
        n0 = got_log.size();
        drv_ready = 1'b0;
        push_words(8'h31, 6);
        repeat (8) tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        push_words(8'h37, 2);
        clear_counts();
        repeat (5) tick();
        check("blk_busy_cycles", fb_cnt, 5);
        check("blk_no_pops", rinc_cnt, 0);
        drv_ready = 1'b1;
        repeat (6) tick();
        check("blk_beats", got_log.size() - n0, 2);
        if (got_log.size() >= n0 + 2) begin
            check("blk_beat0", got_log[n0], {32'h34333231, 4'hF, 1'b0});
            check("blk_beat1", got_log[n0+1], {32'h00003635, 4'h3, 1'b1});
        end

        // Reset mid-beat: two words accumulated and a beat held
        drv_ready = 1'b0;
        push_words(8'h41, 2);
        repeat (3) tick();
        push_words(8'h43, 2);
        repeat (3) tick();
        check("mid_valid_before_rst", out_valid, 1);
        push_words(8'h61, 4);
        rrst_n = 1'b0;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_keep", out_keep, 0);
        check("mid_rst_busy", flush_busy, 0);
        tick();
        rrst_n = 1'b1;
        drv_ready = 1'b1;
        n0 = got_log.size();
        repeat (8) tick();
        check("mid_post_beats", got_log.size() - n0, 1);
        check("mid_post_beat", got_log[$], {32'h64636261, 4'hF, 1'b0});

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drv_ready = ($urandom_range(9) < 7);
            if ($urandom_range(2) == 0 && fifo_q.size() < 20)
                fifo_q.push_back(DSIZE'($urandom));
            drv_flush = ($urandom_range(19) == 0);
            tick();
        end
        drv_flush = 1'b0;
        drv_ready = 1'b1;
        repeat (30) tick();
        drv_flush = 1'b1;
        tick();
        drv_flush = 1'b0;
        repeat (6) tick();
        check("drain_exp_empty", exp_q.size(), 0);
        check("drain_cur_empty", cur.size(), 0);
        check("drain_fifo_empty", fifo_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
